move_entry: RTL

Player-side move producer for the tic-tac-toe turn FSM. It samples the nine square-select switches and a raw confirm button, then validates the selection against its own board-occupancy registers. It offers the accepted move as a 4-bit square index over a valid/ready handshake to the turn logic. It owns the X/O occupancy map that the checker and display blocks read.

---
 rtl/ttt_pkg.sv | 33 +++
 rtl/btn_debounce.sv | 42 ++++
 rtl/move_entry.sv | 113 +++++++++++
 3 files changed

// File: rtl/ttt_pkg.sv
// Shared tic-tac-toe definitions: player codes, square constants, the move FSM
// state encoding and one-hot square helpers used by the move and win logic.
package ttt_pkg;

  localparam logic [1:0] P_NONE = 2'b00;
  localparam logic [1:0] P_X    = 2'b01;
  localparam logic [1:0] P_O    = 2'b10;

  localparam logic [3:0] SQ_NONE = 4'hF;
  localparam int         NUM_SQ  = 9;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SELECT = 2'd1,
    ST_CHECK  = 2'd2,
    ST_OFFER  = 2'd3
  } move_state_e;

  function automatic logic sq_onehot(input logic [NUM_SQ-1:0] v);
    return (v != '0) && ((v & (v - 9'd1)) == '0);
  endfunction

  // Index of the lowest set square, SQ_NONE when no square is selected.
  function automatic logic [3:0] sq_index(input logic [NUM_SQ-1:0] v);
    logic [3:0] idx;
    idx = SQ_NONE;
    for (int i = NUM_SQ - 1; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Confirm-button conditioner: 2-flop synchronizer, saturating debounce counter
// and a single-cycle pulse on the rising edge of the debounced level.
module btn_debounce #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic press_o
);

  localparam int             CW      = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEB_CYCLES);

  logic          sync1_q, sync2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          deb_q;
  logic          deb;

  always_comb begin
    cnt_d = '0;
    if (sync2_q) cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
  end

  assign deb     = (cnt_q == CNT_MAX);
  assign press_o = deb & ~deb_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      deb_q   <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      deb_q   <= deb;
    end
  end

endmodule

// File: rtl/move_entry.sv
// Player move producer: debounced confirm, selection validation against the
// owned X/O occupancy map, and a valid/ready offer of the chosen square index.
module move_entry
  import ttt_pkg::*;
#(
  parameter int DEB_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [8:0]  sw,
  input  logic        confirm,
  input  logic [1:0]  turn,
  input  logic        new_game,
  output logic [3:0]  move,
  output logic        move_valid,
  input  logic        move_ready,
  output logic [8:0]  board_x,
  output logic [8:0]  board_o,
  output logic        full,
  output logic        err
);

  move_state_e state_q;
  logic [8:0]  sw_q;
  logic [1:0]  player_q;
  logic [3:0]  move_q;
  logic        move_valid_q;
  logic [8:0]  board_x_q, board_o_q;
  logic        err_q;

  logic       press;
  logic [8:0] occ;
  logic       turn_ok;
  logic       sel_legal;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_confirm_deb (
    .clk_i   (clk),
    .rst_ni  (rst),
    .btn_i   (confirm),
    .press_o (press)
  );

  assign occ       = board_x_q | board_o_q;
  assign turn_ok   = (turn == P_X) || (turn == P_O);
  assign sel_legal = sq_onehot(sw_q) && ((sw_q & occ) == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      sw_q         <= '0;
      player_q     <= P_NONE;
      move_q       <= SQ_NONE;
      move_valid_q <= 1'b0;
      board_x_q    <= '0;
      board_o_q    <= '0;
      err_q        <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (new_game) begin
        // A clear wins over everything, including a handshake in this cycle.
        state_q      <= ST_IDLE;
        move_q       <= SQ_NONE;
        move_valid_q <= 1'b0;
        board_x_q    <= '0;
        board_o_q    <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (turn_ok && !full) state_q <= ST_SELECT;
          end
          ST_SELECT: begin
            if (!turn_ok) begin
              state_q <= ST_IDLE;
            end else if (press) begin
              sw_q     <= sw;
              player_q <= turn;
              state_q  <= ST_CHECK;
            end
          end
          ST_CHECK: begin
            if (sel_legal) begin
              move_q       <= sq_index(sw_q);
              move_valid_q <= 1'b1;
              state_q      <= ST_OFFER;
            end else begin
              err_q   <= 1'b1;
              state_q <= ST_SELECT;
            end
          end
          ST_OFFER: begin
            // Commit uses the latched square and player, never live inputs.
            if (move_ready) begin
              if (player_q == P_X) board_x_q <= board_x_q | sw_q;
              else                 board_o_q <= board_o_q | sw_q;
              move_q       <= SQ_NONE;
              move_valid_q <= 1'b0;
              state_q      <= ST_IDLE;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign move       = move_q;
  assign move_valid = move_valid_q;
  assign board_x    = board_x_q;
  assign board_o    = board_o_q;
  assign full       = (occ == 9'h1FF);
  assign err        = err_q;

endmodule
